j1_io_ports: RTL
================

J1_IO_PORTS -- requirements
Module: j1_io_ports

Interface
REQ-001 SHALL have parameter WIDTH, default 32, CPU data width.
REQ-002 SHALL have parameter BAUD_DIV, default 104, clk cycles per UART bit (valid range 2..65535).
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port resetq, input, 1, reset; asynchronous, active-low.
REQ-005 SHALL have port io_wr, input, 1, CPU IO write strobe, valid for one cycle.
REQ-006 SHALL have port mem_addr, input, 16, IO address used for both read and write decode.
REQ-007 SHALL have port dout, input, WIDTH, CPU write data.
REQ-008 SHALL have port io_din, output, WIDTH, read data returned to the CPU.
REQ-009 SHALL have port buttons, input, 4, asynchronous board inputs.
REQ-010 SHALL have port leds, output, 8, LED drive register.
REQ-011 SHALL have port uart_tx, output, 1, serial transmit line, idle high.

Function
REQ-012 SHALL decode these addresses: 16'h1000 LED (R/W), 16'h2000 UART data (W), 16'h2001 UART status (R), 16'h4000 tick counter (R/W), 16'h8000 buttons (R).
REQ-013 SHALL drive io_din combinationally from mem_addr and registered state only; the CPU samples it in the same cycle.
REQ-014 SHALL make reads free of side effects; unmapped addresses SHALL read 0; writes to unmapped or read-only addresses SHALL be ignored.
REQ-015 SHALL load leds with dout[7:0] on a cycle with io_wr=1 and mem_addr=16'h1000; LED reads return the value zero-extended to WIDTH.
REQ-016 SHALL pass buttons through a two-flop synchronizer; a reads returns the synchronized value in bits [3:0], zero-extended.
REQ-017 SHALL implement the UART transmitter as an FSM with states IDLE, START, DATA, STOP.
- IDLE: uart_tx=1. A write to 16'h2000 latches dout[7:0] and enters START on the next edge.
- START: uart_tx=0 for BAUD_DIV cycles.
- DATA: 8 bits, LSB first, each held for BAUD_DIV cycles.
- STOP: uart_tx=1 for BAUD_DIV cycles, then return to IDLE.
REQ-018 SHALL make uart_tx go low in the first cycle after the accepting write; one frame SHALL last exactly 10*BAUD_DIV cycles.
REQ-019 SHALL read the status register as bit0 = busy (state != IDLE), other bits 0.
REQ-020 SHALL ignore a data write while busy, including a write in the last STOP cycle; frame contents SHALL not change.
REQ-021 SHALL use a tick counter that is free-running, WIDTH bits, increments every cycle and wraps from all-ones to 0.
REQ-022 SHALL set the tick counter to 0 on a write to 16'h4000 (data ignored); the next cycle it counts from 0 (reads 1 one cycle later).
REQ-023 SHALL register uart_tx and leds as outputs, with no combinational path from inputs.

Reset
REQ-024 SHALL on resetq=0 asynchronously set leds=0, uart_tx=1, FSM=IDLE, tick counter=0, bit/baud counters=0 and synchronizer flops=0.
REQ-025 SHALL abort any frame in flight when reset occurs mid-frame; after release uart_tx stays 1 until a new write.

Configuration
REQ-026 SHALL, when IO_TICKS_EN is defined, include the tick counter per REQ-021/022.
REQ-027 SHALL, when IO_TICKS_EN is undefined, omit the counter hardware; 16'h4000 then reads 0 and writes to it are ignored.

Structure
REQ-028 SHALL place the address constants and the UART state enumeration in shared package j1_io_pkg.
REQ-029 SHALL implement the UART transmitter as sub-module uart_tx_core (ports: clk, resetq, start, data[7:0], busy, tx).

Verification
REQ-030 SHALL cover LED write: io_wr with addr 16'h1000 and dout 32'hABCD_00A5 -> leds=8'hA5 next cycle; a read returns 32'h0000_00A5.
REQ-031 SHALL cover a UART frame with BAUD_DIV=4 and a write of 8'h55 -> uart_tx sequence 0,1,0,1,0,1,0,1,0,1, each bit held 4 cycles; busy=1 for 40 cycles, then 0.
REQ-032 SHALL cover a busy write: a write of 8'hFF at cycle 5 of the 8'h55 frame -> frame unchanged, and no second frame follows.
REQ-033 SHALL cover ticks (IO_TICKS_EN defined): clear write at cycle N -> a read at N+1 returns 0 and at N+11 returns 10; a preload of all-ones wraps to 0.
REQ-034 SHALL cover mid-frame reset: resetq low in the DATA state -> uart_tx=1 and busy=0 immediately; leds=0.
REQ-035 SHALL cover an unmapped read at 16'h3000 -> io_din=0; with buttons=4'b1010 held 2 cycles, a read of 16'h8000 returns 32'hA.

Source files
------------

// File: rtl/j1_io_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | j1_io_pkg : IO address map and UART state encoding for j1 IO.   |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
package j1_io_pkg;

  localparam logic [15:0] ADDR_LED       = 16'h1000;
  localparam logic [15:0] ADDR_UART_DATA = 16'h2000;
  localparam logic [15:0] ADDR_UART_STAT = 16'h2001;
  localparam logic [15:0] ADDR_TICKS     = 16'h4000;
  localparam logic [15:0] ADDR_BUTTONS   = 16'h8000;

  typedef enum logic [1:0] {
    UART_IDLE  = 2'd0,
    UART_START = 2'd1,
    UART_DATA  = 2'd2,
    UART_STOP  = 2'd3
  } uart_state_e;

endpackage
`default_nettype wire

// File: rtl/j1_io_ports_uart_tx_core.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | uart_tx_core : 8N1 transmitter, BAUD_DIV clocks per bit.        |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
module uart_tx_core
  import j1_io_pkg::*;
#(
  parameter int BAUD_DIV = 104
) (
  input  logic       clk,
  input  logic       resetq,
  input  logic       start,
  input  logic [7:0] data,
  output logic       busy,
  output logic       tx
);

  uart_state_e state_q, state_d;
  logic [15:0] baud_q, baud_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic        tx_q, tx_d;
  logic        baud_last;

  assign baud_last = (baud_q == 16'(BAUD_DIV - 1));

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    case (state_q)
      UART_IDLE: begin
        tx_d = 1'b1;
        if (start) begin
          state_d = UART_START;
          shift_d = data;
          baud_d  = 16'd0;
          bit_d   = 3'd0;
          tx_d    = 1'b0;
        end
      end
      UART_START: begin
        if (baud_last) begin
          baud_d  = 16'd0;
          state_d = UART_DATA;
          tx_d    = shift_q[0];
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      UART_DATA: begin
        if (baud_last) begin
          baud_d = 16'd0;
          if (bit_q == 3'd7) begin
            state_d = UART_STOP;
            tx_d    = 1'b1;
          end else begin
            // tx takes the next bit while the shifter advances under it
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
            tx_d    = shift_q[1];
          end
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      UART_STOP: begin
        if (baud_last) begin
          baud_d  = 16'd0;
          state_d = UART_IDLE;
          tx_d    = 1'b1;
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      default: begin
        state_d = UART_IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      state_q <= UART_IDLE;
      baud_q  <= 16'd0;
      bit_q   <= 3'd0;
      shift_q <= 8'd0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

  assign busy = (state_q != UART_IDLE);
  assign tx   = tx_q;

endmodule
`default_nettype wire

// File: rtl/j1_io_ports.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | j1_io_ports : j1 CPU IO block (LEDs, UART TX, ticks, buttons).  |
// | Define IO_TICKS_EN to include the tick counter. Rev 1.0         |
// +-----------------------------------------------------------------+
module j1_io_ports
  import j1_io_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int BAUD_DIV = 104
) (
  input  logic             clk,
  input  logic             resetq,
  input  logic             io_wr,
  input  logic [15:0]      mem_addr,
  input  logic [WIDTH-1:0] dout,
  output logic [WIDTH-1:0] io_din,
  input  logic [3:0]       buttons,
  output logic [7:0]       leds,
  output logic             uart_tx
);

  logic [7:0]       leds_q, leds_d;
  logic [3:0]       btn_meta_q, btn_sync_q;
  logic             uart_start;
  logic             uart_busy;
  logic [WIDTH+7:0] dout_ext;
  logic             unused_dout_hi;

  // Padding lets the LED byte be taken from any WIDTH, even below 8.
  assign dout_ext       = {8'd0, dout};
  assign unused_dout_hi = ^dout_ext[WIDTH+7:8];

  assign uart_start = io_wr && (mem_addr == ADDR_UART_DATA);

  always_comb begin
    leds_d = leds_q;
    if (io_wr && (mem_addr == ADDR_LED)) leds_d = dout_ext[7:0];
  end

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      leds_q     <= 8'd0;
      btn_meta_q <= 4'd0;
      btn_sync_q <= 4'd0;
    end else begin
      leds_q     <= leds_d;
      btn_meta_q <= buttons;
      btn_sync_q <= btn_meta_q;
    end
  end

`ifdef IO_TICKS_EN
  logic [WIDTH-1:0] ticks_q, ticks_d;

  always_comb begin
    ticks_d = ticks_q + WIDTH'(1);
    if (io_wr && (mem_addr == ADDR_TICKS)) ticks_d = '0;
  end

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) ticks_q <= '0;
    else         ticks_q <= ticks_d;
  end
`endif

  always_comb begin
    io_din = '0;
    case (mem_addr)
      ADDR_LED:       io_din = WIDTH'(leds_q);
      ADDR_UART_STAT: io_din = WIDTH'(uart_busy);
`ifdef IO_TICKS_EN
      ADDR_TICKS:     io_din = ticks_q;
`endif
      ADDR_BUTTONS:   io_din = WIDTH'(btn_sync_q);
      default:        io_din = '0;
    endcase
  end

  uart_tx_core #(
    .BAUD_DIV(BAUD_DIV)
  ) u_uart_tx_core (
    .clk   (clk),
    .resetq(resetq),
    .start (uart_start),
    .data  (dout_ext[7:0]),
    .busy  (uart_busy),
    .tx    (uart_tx)
  );

  assign leds = leds_q;

endmodule
`default_nettype wire
